// File: rtl/conv_window_3x3_if.sv
`default_nettype none
// ============================================================================
// conv_window_3x3_if : pixel-stream in / 3x3 window out bundle
// Revision: 1.0
// ============================================================================
interface conv_window_3x3_if #(
  parameter int DATA_W = 9
);
  logic                  in_valid;
  logic                  in_sof;
  logic [DATA_W-1:0]     in_data;
  logic                  win_valid;
  logic [9*DATA_W-1:0]   win_data;
  logic                  frame_done;

  modport master (
    output in_valid, in_sof, in_data,
    input  win_valid, win_data, frame_done
  );

  modport slave (
    input  in_valid, in_sof, in_data,
    output win_valid, win_data, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/conv_window_3x3.sv
`default_nettype none
// ============================================================================
// conv_window_3x3 : two line buffers + 3x3 shift window feeding the MAC array
// Revision: 1.0
// ============================================================================
module conv_window_3x3 #(
  parameter int DATA_W = 9,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  conv_window_3x3_if.slave      bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_WIN  = CW'(2);
  localparam logic [RW-1:0] ROW_WIN  = RW'(2);

  logic [CW-1:0]          col;
  logic [RW-1:0]          row;
  logic [CW-1:0]          col_cur;
  logic [CW-1:0]          col_nxt;
  logic [RW-1:0]          row_cur;
  logic [RW-1:0]          row_nxt;
  logic                   accept;
  logic                   at_win;
  logic                   at_last;

  logic [DATA_W-1:0]      lb0 [IMG_W];
  logic [DATA_W-1:0]      lb1 [IMG_W];
  logic [DATA_W-1:0]      top_px;
  logic [DATA_W-1:0]      mid_px;

  logic [DATA_W-1:0]      win     [9];
  logic [DATA_W-1:0]      win_nxt [9];
  logic [9*DATA_W-1:0]    win_flat;

  logic                   win_valid_r;
  logic                   frame_done_r;
  logic [9*DATA_W-1:0]    win_data_r;

  assign accept  = bus.in_valid;
  // SOF pins the pixel to (0,0) regardless of where the counters are.
  assign col_cur = bus.in_sof ? '0 : col;
  assign row_cur = bus.in_sof ? '0 : row;

  always_comb begin
    col_nxt = col_cur + CW'(1);
    row_nxt = row_cur;
    if (col_cur == COL_LAST) begin
      col_nxt = '0;
      row_nxt = (row_cur == ROW_LAST) ? '0 : row_cur + RW'(1);
    end
  end

  assign at_win  = (row_cur >= ROW_WIN) && (col_cur >= COL_WIN);
  assign at_last = (row_cur == ROW_LAST) && (col_cur == COL_LAST);

  assign top_px = lb1[col_cur];
  assign mid_px = lb0[col_cur];

  // Element index is row*3+col; older columns sit at lower indices.
  always_comb begin
    win_nxt[0] = win[1];
    win_nxt[1] = win[2];
    win_nxt[2] = top_px;
    win_nxt[3] = win[4];
    win_nxt[4] = win[5];
    win_nxt[5] = mid_px;
    win_nxt[6] = win[7];
    win_nxt[7] = win[8];
    win_nxt[8] = bus.in_data;
  end

  for (genvar i = 0; i < 9; i++) begin : g_pack
    assign win_flat[i*DATA_W +: DATA_W] = win_nxt[i];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col          <= '0;
      row          <= '0;
      win_valid_r  <= 1'b0;
      frame_done_r <= 1'b0;
      win_data_r   <= '0;
    end else begin
      win_valid_r  <= accept && at_win;
      frame_done_r <= accept && at_last;
      if (accept) begin
        col <= col_nxt;
        row <= row_nxt;
        if (at_win) begin
          win_data_r <= win_flat;
        end
      end
    end
  end

  // Storage only: never read before rows 0-1 of the current frame rewrite it.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col_cur] <= mid_px;
      lb0[col_cur] <= bus.in_data;
      win          <= win_nxt;
    end
  end

  assign bus.win_valid  = win_valid_r;
  assign bus.frame_done = frame_done_r;
  assign bus.win_data   = win_data_r;
endmodule
`default_nettype wire

// File: tb/tb_conv_window_3x3.sv
`default_nettype none
// ============================================================================
// tb_conv_window_3x3 : randomized + directed bench with image-array reference
// Revision: 1.0
// ============================================================================
module tb_conv_window_3x3;
  localparam int DW = 9;
  localparam int W  = 5;
  localparam int H  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  conv_window_3x3_if #(.DATA_W(DW)) bus ();

  conv_window_3x3 #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Reference: frame held as a 2-D image; windows read straight out of it.
  int                mr, mc;
  logic [DW-1:0]     img [H][W];
  logic              m_valid, m_done;
  logic [9*DW-1:0]   m_win;

  task automatic model_reset();
    mr = 0; mc = 0; m_valid = 1'b0; m_done = 1'b0; m_win = '0;
  endtask

  task automatic model(input logic v, input logic s, input logic [DW-1:0] d);
    m_valid = 1'b0;
    m_done  = 1'b0;
    if (v) begin
      if (s) begin mr = 0; mc = 0; end
      img[mr][mc] = d;
      if (mr >= 2 && mc >= 2) begin
        m_valid = 1'b1;
        for (int i = 0; i < 9; i++)
          m_win[i*DW +: DW] = img[mr-2+i/3][mc-2+i%3];
        m_done = (mr == H-1) && (mc == W-1);
      end
      mc++;
      if (mc == W) begin
        mc = 0; mr++;
        if (mr == H) mr = 0;
      end
    end
  endtask

  // One clock: drive at negedge, sample 1 ns after the rising edge.
  task automatic step(input logic v, input logic s, input logic [DW-1:0] d);
    @(negedge clk);
    bus.in_valid = v; bus.in_sof = s; bus.in_data = d;
    @(posedge clk); #1;
    model(v, s, d);
  endtask

  function automatic logic [9*DW-1:0] pack9(input int base, input int off);
    logic [9*DW-1:0] r;
    for (int i = 0; i < 9; i++) r[i*DW +: DW] = DW'(off + base + (i/3)*W + (i%3));
    return r;
  endfunction

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_data = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.win_valid !== 1'b0 || bus.frame_done !== 1'b0 || bus.win_data !== '0) begin
      errors++;
      $display("FAIL reset: valid/done/data=%b/%b/%h expected 0/0/0", bus.win_valid, bus.frame_done, bus.win_data);
    end
    @(negedge clk); rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_single_frame();
    int n = 0;
    for (int k = 0; k < W*H; k++) begin
      step(1'b1, k == 0, DW'(k));
      checks++;
      if (bus.win_valid !== m_valid || bus.frame_done !== m_done || bus.win_data !== m_win) begin
        errors++;
        $display("FAIL single beat %0d: v/d/data=%b/%b/%h expected %b/%b/%h", k, bus.win_valid, bus.frame_done, bus.win_data, m_valid, m_done, m_win);
      end
      if (bus.win_valid === 1'b1) n++;
      if (k == 12) begin
        checks++;
        if (bus.win_valid !== 1'b1 || bus.win_data !== pack9(0, 0)) begin
          errors++;
          $display("FAIL single first window: %b/%h expected 1/%h", bus.win_valid, bus.win_data, pack9(0, 0));
        end
      end
      if (k == W*H-1) begin
        checks++;
        if (bus.frame_done !== 1'b1 || bus.win_data !== pack9(7, 0)) begin
          errors++;
          $display("FAIL single last window: %b/%h expected 1/%h", bus.frame_done, bus.win_data, pack9(7, 0));
        end
      end
    end
    checks++;
    if (n != 6) begin errors++; $display("FAIL single count: %0d expected 6", n); end
  endtask

  task automatic test_gaps();
    int n = 0;
    for (int k = 0; k < W*H; k++) begin
      step(1'b1, k == 0, DW'(k));
      checks++;
      if (bus.win_valid !== m_valid || bus.frame_done !== m_done || bus.win_data !== m_win) begin
        errors++;
        $display("FAIL gaps beat %0d: v/d/data=%b/%b/%h expected %b/%b/%h", k, bus.win_valid, bus.frame_done, bus.win_data, m_valid, m_done, m_win);
      end
      if (bus.win_valid === 1'b1) n++;
      if (k % 2 == 1) begin
        for (int g = 0; g < 3; g++) begin
          step(1'b0, 1'b0, DW'($urandom));
          checks++;
          if (bus.win_valid !== 1'b0 || bus.frame_done !== 1'b0 || bus.win_data !== m_win) begin
            errors++;
            $display("FAIL gaps idle after %0d: v/d/data=%b/%b/%h expected 0/0/%h", k, bus.win_valid, bus.frame_done, bus.win_data, m_win);
          end
        end
      end
    end
    checks++;
    if (n != 6) begin errors++; $display("FAIL gaps count: %0d expected 6", n); end
  endtask

  task automatic test_back_to_back();
    int n = 0, nd = 0;
    for (int k = 0; k < 2*W*H; k++) begin
      int idx = k % (W*H);
      step(1'b1, k == 0, DW'((k < W*H) ? idx : 100 + idx));
      checks++;
      if (bus.win_valid !== m_valid || bus.frame_done !== m_done || bus.win_data !== m_win) begin
        errors++;
        $display("FAIL b2b beat %0d: v/d/data=%b/%b/%h expected %b/%b/%h", k, bus.win_valid, bus.frame_done, bus.win_data, m_valid, m_done, m_win);
      end
      if (bus.win_valid === 1'b1) n++;
      if (bus.frame_done === 1'b1) nd++;
      if (k == W*H + 12) begin
        checks++;
        if (bus.win_valid !== 1'b1 || bus.win_data !== pack9(0, 100)) begin
          errors++;
          $display("FAIL b2b frame2 first window: %b/%h expected 1/%h", bus.win_valid, bus.win_data, pack9(0, 100));
        end
      end
    end
    checks++;
    if (n != 12 || nd != 2) begin errors++; $display("FAIL b2b counts: strobes %0d done %0d expected 12 2", n, nd); end
  endtask

  task automatic test_sof_abort();
    int early = 0;
    for (int k = 0; k <= 8; k++) begin
      step(1'b1, k == 0, DW'(50 + k));
      if (bus.win_valid === 1'b1) early++;
    end
    for (int k = 0; k < W*H; k++) begin
      step(1'b1, k == 0, DW'(200 + k));
      checks++;
      if (bus.win_valid !== m_valid || bus.frame_done !== m_done || bus.win_data !== m_win) begin
        errors++;
        $display("FAIL abort beat %0d: v/d/data=%b/%b/%h expected %b/%b/%h", k, bus.win_valid, bus.frame_done, bus.win_data, m_valid, m_done, m_win);
      end
      if (k < 12 && bus.win_valid === 1'b1) early++;
      if (k == 12) begin
        checks++;
        if (bus.win_valid !== 1'b1 || bus.win_data !== pack9(0, 200)) begin
          errors++;
          $display("FAIL abort first window: %b/%h expected 1/%h", bus.win_valid, bus.win_data, pack9(0, 200));
        end
      end
    end
    checks++;
    if (early != 0) begin errors++; $display("FAIL abort early strobes: %0d expected 0", early); end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k <= 13; k++) step(1'b1, k == 0, DW'(k));
    @(negedge clk);
    bus.in_valid = 1'b0; bus.in_sof = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.win_valid !== 1'b0 || bus.frame_done !== 1'b0 || bus.win_data !== '0) begin
      errors++;
      $display("FAIL midreset outputs: v/d/data=%b/%b/%h expected 0/0/0", bus.win_valid, bus.frame_done, bus.win_data);
    end
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    test_single_frame();
  endtask

  task automatic test_sof_idle();
    int n = 0;
    for (int k = 0; k < W*H; k++) begin
      if (k == 8) step(1'b0, 1'b1, DW'(77));
      step(1'b1, k == 0, DW'(k));
      checks++;
      if (bus.win_valid !== m_valid || bus.frame_done !== m_done || bus.win_data !== m_win) begin
        errors++;
        $display("FAIL sofidle beat %0d: v/d/data=%b/%b/%h expected %b/%b/%h", k, bus.win_valid, bus.frame_done, bus.win_data, m_valid, m_done, m_win);
      end
      if (bus.win_valid === 1'b1) n++;
    end
    checks++;
    if (n != 6 || bus.win_data !== pack9(7, 0)) begin
      errors++;
      $display("FAIL sofidle summary: count %0d last %h expected 6 %h", n, bus.win_data, pack9(7, 0));
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      logic v, s;
      v = ($urandom_range(0, 3) != 0);
      s = (k == 0) || ($urandom_range(0, 60) == 0);
      step(v, s, DW'($urandom));
      checks++;
      if (bus.win_valid !== m_valid || bus.frame_done !== m_done || bus.win_data !== m_win) begin
        errors++;
        $display("FAIL random cycle %0d: v/d/data=%b/%b/%h expected %b/%b/%h", k, bus.win_valid, bus.frame_done, bus.win_data, m_valid, m_done, m_win);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_frame();
    test_gaps();
    test_back_to_back();
    test_sof_abort();
    test_reset_mid();
    test_sof_idle();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
